dm: RTL and testbench

- Data memory for the single-cycle MIPS datapath.
- Sits directly downstream of the ALU: the ALU result is the byte address, and the rt register value is the store data.
- Performs sw/sh/sb stores with byte-lane merging on the clock edge.
- Returns lw/lh/lhu/lb/lbu load data combinationally, with sign or zero extension, to the register-file write-back mux.

---
 rtl/dm.sv | 85 ++++++++
 tb/tb_dm.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dm.sv
// rtl/dm.sv - single-cycle MIPS data memory with byte-lane stores and extending loads
module dm #(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic [1:0]  StoreOp,
    input  logic [2:0]  LoadOp,
    output logic [31:0] RD
);

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             do_store;
    logic [31:0]      w;
    logic [31:0]      merged;
    logic [15:0]      half;
    logic [7:0]       byte_sel;

    assign idx      = Addr[IDX_W+1:2];
    assign in_range = (32'(idx) < DEPTH_WORDS) && (Addr[31:IDX_W+2] == '0);
    assign w        = in_range ? mem[idx] : 32'h0;
    assign do_store = MemWrite && in_range && (StoreOp != 2'b11);

    // Merged word is computed from the current contents so untouched lanes survive.
    always_comb begin
        merged = w;
        case (StoreOp)
            2'b00: merged = WD;
            2'b01: begin
                if (Addr[1]) merged[31:16] = WD[15:0];
                else         merged[15:0]  = WD[15:0];
            end
            2'b10: begin
                case (Addr[1:0])
                    2'b00:   merged[7:0]   = WD[7:0];
                    2'b01:   merged[15:8]  = WD[7:0];
                    2'b10:   merged[23:16] = WD[7:0];
                    default: merged[31:24] = WD[7:0];
                endcase
            end
            default: merged = w;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (do_store) begin
            mem[idx] <= merged;
            $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, merged);
        end
    end

    always_comb begin
        half = Addr[1] ? w[31:16] : w[15:0];
        case (Addr[1:0])
            2'b00:   byte_sel = w[7:0];
            2'b01:   byte_sel = w[15:8];
            2'b10:   byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    end

    always_comb begin
        RD = w;
        case (LoadOp)
            3'b000:  RD = w;
            3'b001:  RD = {{16{half[15]}}, half};
            3'b010:  RD = {16'h0, half};
            3'b011:  RD = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  RD = {24'h0, byte_sel};
            default: RD = w;
        endcase
    end

endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - directed scoreboard bench for the dm data memory
module tb_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        MemWrite;
    logic [1:0]  StoreOp;
    logic [2:0]  LoadOp;
    logic [31:0] RD;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;
    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SRSV = 2'b11;

    dm #(.DEPTH_WORDS(3072), .IDX_W(12)) dut (
        .clk(clk), .reset(reset), .PC(PC), .Addr(Addr), .WD(WD),
        .MemWrite(MemWrite), .StoreOp(StoreOp), .LoadOp(LoadOp), .RD(RD)
    );

    always #5 clk = ~clk;

    task automatic expect_rd(input string tag, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (RD === e) passed++;
        else $error("FAIL %s: RD=%h expected %h", t, RD, e);
    endtask

    task automatic load(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] exp);
        @(negedge clk);
        MemWrite = 1'b0;
        LoadOp   = op;
        Addr     = a;
        expect_rd(tag, exp);
    endtask

    task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic we);
        @(negedge clk);
        MemWrite = we;
        StoreOp  = op;
        Addr     = a;
        WD       = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PC = 32'h0; Addr = 32'h0; WD = 32'h0;
        MemWrite = 1'b0; StoreOp = SW; LoadOp = LW;
        @(posedge clk);
        #1 reset = 1'b0;

        load("rst_lw_0",    LW, 32'h0,    32'h0);
        load("rst_lw_4",    LW, 32'h4,    32'h0);
        load("rst_lw_2ffc", LW, 32'h2FFC, 32'h0);
        for (int op = 0; op < 8; op++) begin
            load($sformatf("rst_op%0d", op), 3'(op), 32'h13, 32'h0);
        end

        PC = 32'h00003000;
        store(SW, 32'h10, 32'h89ABCDEF, 1'b1);
        load("sw_lw",     LW,     32'h10, 32'h89ABCDEF);
        load("sw_lh",     LH,     32'h12, 32'hFFFF89AB);
        load("sw_lhu",    LHU,    32'h12, 32'h000089AB);
        load("sw_lb0",    LB,     32'h10, 32'hFFFFFFEF);
        load("sw_lbu0",   LBU,    32'h10, 32'h000000EF);
        load("sw_lh_lo",  LH,     32'h10, 32'hFFFFCDEF);
        load("rsv_load",  3'b101, 32'h12, 32'h89ABCDEF);

        PC = 32'h00003004;
        store(SW, 32'h20, 32'h11223344, 1'b1);
        store(SB, 32'h21, 32'h000000F0, 1'b1);
        load("sb_merge",  LW,  32'h20, 32'h1122F044);
        load("sb_lb21",   LB,  32'h21, 32'hFFFFFFF0);
        load("sb_lbu21",  LBU, 32'h21, 32'h000000F0);
        load("sb_lb23",   LB,  32'h23, 32'h00000011);
        store(SB, 32'h22, 32'h00000099, 1'b1);
        load("sb_lane2",  LW,  32'h20, 32'h1199F044);

        store(SH, 32'h42, 32'hDEAD7FFF, 1'b1);
        load("sh_hi_word", LW, 32'h40, 32'h7FFF0000);
        load("sh_hi_lh",   LH, 32'h42, 32'h00007FFF);
        load("sh_lo_lh",   LH, 32'h40, 32'h00000000);
        store(SH, 32'h51, 32'h12345678, 1'b1);
        load("sh_lo_a0",   LW, 32'h50, 32'h00005678);
        store(SW, 32'h63, 32'hCAFEF00D, 1'b1);
        load("sw_unalign", LW, 32'h60, 32'hCAFEF00D);

        store(SW, 32'h3000, 32'h00000055, 1'b1);
        load("oor_3000",   LW, 32'h3000, 32'h0);
        load("oor_noalias", LW, 32'h0,   32'h0);
        store(SW, 32'h4010, 32'h00000BAD, 1'b1);
        load("oor_hi_bits", LW, 32'h10,  32'h89ABCDEF);
        load("oor_hi_read", LW, 32'h4010, 32'h0);
        store(SRSV, 32'h10, 32'h0, 1'b1);
        load("rsv_store",  LW, 32'h10, 32'h89ABCDEF);
        store(SW, 32'h10, 32'h0, 1'b0);
        load("memwrite0",  LW, 32'h10, 32'h89ABCDEF);
        store(SW, 32'h2FFC, 32'h00000055, 1'b1);
        load("last_word",  LW, 32'h2FFC, 32'h00000055);

        store(SW, 32'h8, 32'hAAAAAAAA, 1'b1);
        load("pre_rst_8",  LW, 32'h8, 32'hAAAAAAAA);
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b1; StoreOp = SW; Addr = 32'h8; WD = 32'h12345678;
        @(posedge clk);
        #1 reset = 1'b0; MemWrite = 1'b0;
        load("rst_drop_8",  LW, 32'h8,    32'h0);
        load("rst_clr_10",  LW, 32'h10,   32'h0);
        load("rst_clr_2ffc", LW, 32'h2FFC, 32'h0);

        @(negedge clk);
        MemWrite = 1'b1; StoreOp = SW; LoadOp = LW; Addr = 32'h8; WD = 32'h00000001;
        expect_rd("rdw_before", 32'h0);
        @(posedge clk);
        expect_rd("rdw_after", 32'h00000001);
        MemWrite = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
